// File: rtl/alu2_pkg.sv
// alu2_pkg: shared definitions for the RV64 integer ALU.
//   - alu_op_e  : 4-bit ALUControl opcode encoding
//   - XLEN_DEFAULT : default datapath width
//   - ALU_ADD   : opcode driven by the fetch-stage PC+4 adder
package alu2_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SRA  = 4'b1000,
    OP_SLTU = 4'b1001
  } alu_op_e;

  localparam logic [3:0] ALU_ADD = 4'b0010;

endpackage

// File: rtl/alu2_shifter.sv
// alu2_shifter: barrel shifter for SLL/SRL/SRA.
// Ports:
//   data   - value to shift
//   shamt  - 6-bit shift amount (already truncated by the caller)
//   sll_o  - logical left shift result
//   srl_o  - logical right shift result
//   sra_o  - arithmetic right shift result
// All three results are produced in parallel; the ALU selects one.
module alu2_shifter
  import alu2_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] data,
  input  logic [5:0]      shamt,
  output logic [XLEN-1:0] sll_o,
  output logic [XLEN-1:0] srl_o,
  output logic [XLEN-1:0] sra_o
);

  always_comb begin
    sll_o = data << shamt;
    srl_o = data >> shamt;
    sra_o = $unsigned($signed(data) >>> shamt);
  end

endmodule

// File: rtl/alu2.sv
// alu2: 64-bit integer ALU for the RV64 pipeline (execute stage and
// fetch-stage PC+4 adder).
// Ports:
//   clk, reset        - clock; asynchronous active-high reset (registered outputs only)
//   rs1, rs2          - operands
//   ALUControl        - operation select (see alu2_pkg::alu_op_e; 1010-1111 give rd = 0)
//   rd, zero          - combinational result and rd == 0 flag
//   rd_q, zero_q      - rd and zero registered on clk
// Optional (macro ALU2_FLAGS_EN):
//   carry, overflow, negative - combinational status flags
//   flags_q                   - {carry, overflow, negative} registered on clk
module alu2
  import alu2_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [XLEN-1:0]        rs1,
  input  logic [XLEN-1:0]        rs2,
  input  logic [3:0]             ALUControl,
  output logic signed [XLEN-1:0] rd,
  output logic                   zero,
  output logic [XLEN-1:0]        rd_q,
  output logic                   zero_q
`ifdef ALU2_FLAGS_EN
  ,
  output logic                   carry,
  output logic                   overflow,
  output logic                   negative,
  output logic [2:0]             flags_q
`endif
);

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] sll_r;
  logic [XLEN-1:0] srl_r;
  logic [XLEN-1:0] sra_r;
  logic            lt_signed;
  logic            lt_unsigned;
  logic [XLEN-1:0] result;

  alu2_shifter #(.XLEN(XLEN)) u_shifter (
    .data  (rs1),
    .shamt (rs2[5:0]),
    .sll_o (sll_r),
    .srl_o (srl_r),
    .sra_o (sra_r)
  );

`ifdef ALU2_FLAGS_EN
  // Extra top bit captures carry-out on add and borrow on subtract.
  logic [XLEN:0] sum_w;
  logic [XLEN:0] diff_w;

  always_comb begin
    sum_w  = {1'b0, rs1} + {1'b0, rs2};
    diff_w = {1'b0, rs1} - {1'b0, rs2};
    sum    = sum_w[XLEN-1:0];
    diff   = diff_w[XLEN-1:0];
  end
`else
  always_comb begin
    sum  = rs1 + rs2;
    diff = rs1 - rs2;
  end
`endif

  always_comb begin
    lt_signed   = $signed(rs1) < $signed(rs2);
    lt_unsigned = rs1 < rs2;
  end

  always_comb begin
    result = '0;
    case (ALUControl)
      OP_AND:  result = rs1 & rs2;
      OP_OR:   result = rs1 | rs2;
      OP_ADD:  result = sum;
      OP_XOR:  result = rs1 ^ rs2;
      OP_SLL:  result = sll_r;
      OP_SRL:  result = srl_r;
      OP_SUB:  result = diff;
      OP_SLT:  result = {{(XLEN-1){1'b0}}, lt_signed};
      OP_SRA:  result = sra_r;
      OP_SLTU: result = {{(XLEN-1){1'b0}}, lt_unsigned};
      default: result = '0;
    endcase
  end

  always_comb begin
    rd   = $signed(result);
    zero = (result == '0);
  end

`ifdef ALU2_FLAGS_EN
  always_comb begin
    carry    = 1'b0;
    overflow = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        carry    = sum_w[XLEN];
        overflow = (rs1[XLEN-1] == rs2[XLEN-1]) && (sum[XLEN-1] != rs1[XLEN-1]);
      end
      OP_SUB: begin
        // Carry on subtract is borrow-not: set when rs1 >= rs2 unsigned.
        carry    = ~diff_w[XLEN];
        overflow = (rs1[XLEN-1] != rs2[XLEN-1]) && (diff[XLEN-1] != rs1[XLEN-1]);
      end
      default: ;
    endcase
    negative = result[XLEN-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags_q <= '0;
    else       flags_q <= {carry, overflow, negative};
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q   <= '0;
      zero_q <= 1'b0;
    end else begin
      rd_q   <= result;
      zero_q <= zero;
    end
  end

endmodule

// File: tb/tb_alu2.sv
module tb_alu2;

  logic               clk;
  logic               reset;
  logic [63:0]        rs1;
  logic [63:0]        rs2;
  logic [3:0]         ALUControl;
  logic signed [63:0] rd;
  logic               zero;
  logic [63:0]        rd_q;
  logic               zero_q;
`ifdef ALU2_FLAGS_EN
  logic               carry;
  logic               overflow;
  logic               negative;
  logic [2:0]         flags_q;
`endif

  int unsigned checks;
  int unsigned passed;

  alu2 #(.XLEN(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .rs1        (rs1),
    .rs2        (rs2),
    .ALUControl (ALUControl),
    .rd         (rd),
    .zero       (zero),
    .rd_q       (rd_q),
    .zero_q     (zero_q)
`ifdef ALU2_FLAGS_EN
    ,
    .carry      (carry),
    .overflow   (overflow),
    .negative   (negative),
    .flags_q    (flags_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: arithmetic definitions of each operation.
  function automatic logic [63:0] ref_rd(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] sign_flip;
    logic [63:0] pow2;
    logic [63:0] fill;
    int unsigned s;
    sign_flip = 64'h8000_0000_0000_0000;
    s    = int'(b % 64);
    pow2 = 64'd1 << s;
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a ^ b;
      4'd4:    return a * pow2;
      4'd5:    return a / pow2;
      4'd6:    return a + (~b + 64'd1);
      4'd7:    return ((a ^ sign_flip) < (b ^ sign_flip)) ? 64'd1 : 64'd0;
      4'd8: begin
        fill = '0;
        for (int i = 0; i < s; i++) fill[63 - i] = a[63];
        return (a / pow2) | fill;
      end
      4'd9:    return (a < b) ? 64'd1 : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [2:0] ref_flags(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] wa, wb, ws;
    logic c, v;
    logic [63:0] r;
    wa = {{64{a[63]}}, a};
    wb = {{64{b[63]}}, b};
    r  = ref_rd(op, a, b);
    c  = 1'b0;
    v  = 1'b0;
    if (op == 4'd2) begin
      c  = (a + b) < a;
      ws = wa + wb;
      v  = (ws > 128'sh7FFF_FFFF_FFFF_FFFF) || (ws < -128'sh8000_0000_0000_0000);
    end else if (op == 4'd6) begin
      c  = (a >= b);
      ws = wa - wb;
      v  = (ws > 128'sh7FFF_FFFF_FFFF_FFFF) || (ws < -128'sh8000_0000_0000_0000);
    end
    return {c, v, r[63]};
  endfunction

  task automatic apply(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    ALUControl = op;
    rs1 = a;
    rs2 = b;
    #1;
  endtask

  task automatic check_comb(input string name, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] exp_rd;
    exp_rd = ref_rd(op, a, b);
    checks++;
    if (rd !== exp_rd)
      $display("FAIL %s rd op=%0h a=%h b=%h got=%h exp=%h", name, op, a, b, rd, exp_rd);
    else passed++;
    checks++;
    if (zero !== (exp_rd == 64'd0))
      $display("FAIL %s zero op=%0h got=%b exp=%b", name, op, zero, exp_rd == 64'd0);
    else passed++;
`ifdef ALU2_FLAGS_EN
    checks++;
    if ({carry, overflow, negative} !== ref_flags(op, a, b))
      $display("FAIL %s flags op=%0h a=%h b=%h got=%b exp=%b", name, op, a, b,
               {carry, overflow, negative}, ref_flags(op, a, b));
    else passed++;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ALUControl = 4'b0010;
    rs1 = 64'd2;
    rs2 = 64'd3;
    #2;
    checks++;
    if (rd_q !== 64'd0 || zero_q !== 1'b0)
      $display("FAIL reset_state rd_q=%h zero_q=%b exp rd_q=0 zero_q=0", rd_q, zero_q);
    else passed++;
    checks++;
    if (rd !== 64'sd5)
      $display("FAIL reset_comb rd=%h exp=5", rd);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [3:0]  op  [20];
    logic [63:0] va  [20];
    logic [63:0] vb  [20];
    logic [63:0] er  [20];
    op[0]=4'h2;  va[0]=64'h10;                  vb[0]=64'd4;   er[0]=64'h14;
    op[1]=4'h2;  va[1]=64'hFFFF_FFFF_FFFF_FFFC; vb[1]=64'd4;   er[1]=64'h0;
    op[2]=4'h6;  va[2]=64'd5;                   vb[2]=64'd7;   er[2]=64'hFFFF_FFFF_FFFF_FFFE;
    op[3]=4'h7;  va[3]=64'd5;                   vb[3]=64'd7;   er[3]=64'd1;
    op[4]=4'h9;  va[4]='1;                      vb[4]=64'd1;   er[4]=64'd0;
    op[5]=4'h7;  va[5]='1;                      vb[5]=64'd1;   er[5]=64'd1;
    op[6]=4'h5;  va[6]=64'h8000_0000_0000_0000; vb[6]=64'h43;  er[6]=64'h1000_0000_0000_0000;
    op[7]=4'h8;  va[7]=64'h8000_0000_0000_0000; vb[7]=64'h43;  er[7]=64'hF000_0000_0000_0000;
    op[8]=4'h4;  va[8]=64'd1;                   vb[8]=64'd63;  er[8]=64'h8000_0000_0000_0000;
    op[9]=4'h0;  va[9]=64'hF0F0;                vb[9]=64'hFF00; er[9]=64'hF000;
    op[10]=4'h1; va[10]=64'hF0F0;               vb[10]=64'hFF00; er[10]=64'hFFF0;
    op[11]=4'h3; va[11]=64'hF0F0;               vb[11]=64'hFF00; er[11]=64'h0FF0;
    op[12]=4'hF; va[12]=64'hF0F0;               vb[12]=64'hFF00; er[12]=64'h0;
    op[13]=4'hA; va[13]='1;                     vb[13]='1;     er[13]=64'h0;
    op[14]=4'h2; va[14]=64'h7FFF_FFFF_FFFF_FFFF; vb[14]=64'd1; er[14]=64'h8000_0000_0000_0000;
    op[15]=4'h4; va[15]=64'h3;                  vb[15]=64'hFFFF_FFFF_FFFF_FFC1; er[15]=64'h6;
    op[16]=4'h8; va[16]=64'h7000_0000_0000_0000; vb[16]=64'd4; er[16]=64'h0700_0000_0000_0000;
    op[17]=4'h6; va[17]=64'h8000_0000_0000_0000; vb[17]=64'd1; er[17]=64'h7FFF_FFFF_FFFF_FFFF;
    op[18]=4'h9; va[18]=64'd1;                  vb[18]='1;     er[18]=64'd1;
    op[19]=4'h7; va[19]=64'd1;                  vb[19]='1;     er[19]=64'd0;
    for (int i = 0; i < 20; i++) begin
      apply(op[i], va[i], vb[i]);
      checks++;
      if (rd !== er[i])
        $display("FAIL directed_%0d rd got=%h exp=%h", i, rd, er[i]);
      else passed++;
      checks++;
      if (zero !== (er[i] == 64'd0))
        $display("FAIL directed_%0d zero got=%b exp=%b", i, zero, er[i] == 64'd0);
      else passed++;
    end
  endtask

  task automatic test_flags();
`ifdef ALU2_FLAGS_EN
    apply(4'h2, 64'hFFFF_FFFF_FFFF_FFFC, 64'd4);
    checks++;
    if ({carry, overflow} !== 2'b10)
      $display("FAIL flags_wrap got c/v=%b%b exp=10", carry, overflow);
    else passed++;
    apply(4'h2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    checks++;
    if ({carry, overflow, negative} !== 3'b011)
      $display("FAIL flags_ovf got=%b exp=011", {carry, overflow, negative});
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if (flags_q !== 3'b011)
      $display("FAIL flags_q got=%b exp=011", flags_q);
    else passed++;
    apply(4'h6, 64'd7, 64'd7);
    checks++;
    if (carry !== 1'b1)
      $display("FAIL flags_sub_eq carry got=%b exp=1", carry);
    else passed++;
`endif
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [63:0] a, b, exp_rd;
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = a;
        1: b = 64'($urandom_range(0, 70));
        2: a = 64'h8000_0000_0000_0000;
        3: a = 64'h7FFF_FFFF_FFFF_FFFF;
        default: ;
      endcase
      apply(op, a, b);
      check_comb("random", op, a, b);
      exp_rd = ref_rd(op, a, b);
      @(posedge clk);
      #1;
      checks++;
      if (rd_q !== exp_rd || zero_q !== (exp_rd == 64'd0))
        $display("FAIL random_reg rd_q=%h zero_q=%b exp rd_q=%h zero_q=%b",
                 rd_q, zero_q, exp_rd, exp_rd == 64'd0);
      else passed++;
    end
  endtask

  task automatic test_registered_reset();
    apply(4'h2, 64'd2, 64'd3);
    @(posedge clk);
    #1;
    checks++;
    if (rd_q !== 64'd5 || zero_q !== 1'b0)
      $display("FAIL reg_capture rd_q=%h zero_q=%b exp 5/0", rd_q, zero_q);
    else passed++;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (rd_q !== 64'd0 || zero_q !== 1'b0)
      $display("FAIL async_reset rd_q=%h zero_q=%b exp 0/0", rd_q, zero_q);
    else passed++;
    checks++;
    if (rd !== 64'sd5 || zero !== 1'b0)
      $display("FAIL reset_no_comb_effect rd=%h zero=%b exp 5/0", rd, zero);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (rd_q !== 64'd5)
      $display("FAIL reset_release rd_q=%h exp=5", rd_q);
    else passed++;
    // Zero result registers zero_q high.
    apply(4'h6, 64'd9, 64'd9);
    @(posedge clk);
    #1;
    checks++;
    if (rd_q !== 64'd0 || zero_q !== 1'b1)
      $display("FAIL reg_zero rd_q=%h zero_q=%b exp 0/1", rd_q, zero_q);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, b;
    logic [63:0] prev;
    prev = '0;
    for (int i = 0; i < 20; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      @(negedge clk);
      ALUControl = 4'h2;
      rs1 = a;
      rs2 = b;
      if (i > 0) begin
        checks++;
        if (rd_q !== prev)
          $display("FAIL back_to_back_%0d rd_q=%h exp=%h", i, rd_q, prev);
        else passed++;
      end
      prev = a + b;
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rs1 = '0;
    rs2 = '0;
    ALUControl = '0;
    test_reset();
    test_directed();
    test_flags();
    test_registered_reset();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
